// File: rtl/genius_pkg.sv
// Shared encodings and helpers for the parametrised Genius control unit.
package genius_pkg;

  localparam int unsigned ESTADO_W = 5;

  localparam logic [4:0] INICIAL          = 5'd0;
  localparam logic [4:0] PREPARA          = 5'd1;
  localparam logic [4:0] MOSTRA           = 5'd2;
  localparam logic [4:0] INTERVALO        = 5'd3;
  localparam logic [4:0] PROX_MOSTRA      = 5'd4;
  localparam logic [4:0] INICIA_SEQ       = 5'd5;
  localparam logic [4:0] ESPERA           = 5'd6;
  localparam logic [4:0] REGISTRA         = 5'd7;
  localparam logic [4:0] COMPARA          = 5'd8;
  localparam logic [4:0] PROX_JOGADA      = 5'd9;
  localparam logic [4:0] ULTIMA           = 5'd10;
  localparam logic [4:0] INTERVALO_RODADA = 5'd11;
  localparam logic [4:0] PROX_RODADA      = 5'd12;
  localparam logic [4:0] PERDE_VIDA       = 5'd13;
  localparam logic [4:0] FINAL_ACERTOU    = 5'd14;
  localparam logic [4:0] FINAL_ERROU      = 5'd15;
  localparam logic [4:0] FINAL_TIMEOUT    = 5'd16;

  localparam logic [1:0] DIF_QUARTO   = 2'b00;
  localparam logic [1:0] DIF_METADE   = 2'b01;
  localparam logic [1:0] DIF_TRES_QTS = 2'b10;
  localparam logic [1:0] DIF_TOTAL    = 2'b11;

  // Game length for a given difficulty code.
  function automatic int unsigned comprimento_jogo(input int unsigned max_seq,
                                                   input logic [1:0] dif);
    case (dif)
      DIF_QUARTO:   return max_seq / 4;
      DIF_METADE:   return max_seq / 2;
      DIF_TRES_QTS: return (3 * max_seq) / 4;
      default:      return max_seq;
    endcase
  endfunction

endpackage

// File: rtl/contador_param.sv
// Modulo-M up counter with synchronous clear; fim flags the terminal count.
module contador_param #(
  parameter int unsigned M = 16,
  parameter int unsigned W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         fim
);

  always_ff @(posedge clock) begin
    if (reset || zera) q <= '0;
    else if (conta)    q <= (q == W'(M - 1)) ? '0 : q + W'(1);
  end

  assign fim = (q == W'(M - 1));

endmodule

// File: rtl/genius_controle_param.sv
// Genius minigame controller: show a growing sequence, check plays, track lives.
module genius_controle_param
  import genius_pkg::*;
#(
  parameter int unsigned N_BOTOES    = 4,
  parameter int unsigned MAX_SEQ     = 16,
  parameter int unsigned T_MOSTRA    = 50,
  parameter int unsigned T_INTERVALO = 25,
  parameter int unsigned T_TIMEOUT   = 500,
  parameter int unsigned VIDAS       = 3,
  localparam int unsigned AW = $clog2(MAX_SEQ),
  localparam int unsigned DW = $clog2(N_BOTOES),
  localparam int unsigned RW = AW + 1,
  localparam int unsigned VW = $clog2(VIDAS) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [1:0]          dificuldade,
  output logic [AW-1:0]       mem_endereco,
  input  logic [DW-1:0]       mem_dado,
  output logic [N_BOTOES-1:0] leds,
  output logic [RW-1:0]       rodada,
  output logic [VW-1:0]       vidas_restantes,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                fim_timeout,
  output logic [4:0]          db_estado
);

  localparam int unsigned T_MAX =
    (T_MOSTRA > T_INTERVALO) ? ((T_MOSTRA > T_TIMEOUT) ? T_MOSTRA : T_TIMEOUT)
                             : ((T_INTERVALO > T_TIMEOUT) ? T_INTERVALO : T_TIMEOUT);
  localparam int unsigned TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [N_BOTOES-1:0] UM = N_BOTOES'(1);

  logic [4:0]          estado, proximo;
  logic [AW-1:0]       endereco;
  logic [RW-1:0]       comprimento;
  logic [N_BOTOES-1:0] botoes_d, jogada_reg;
  logic                causa_timeout, repete;
  logic [TW-1:0]       tempo;
  logic                tempo_fim_unused;
  logic                jogada, correto, ultimo_passo, esgotou;

  // Shared timer restarts on every state change, so each timed state starts at 0.
  contador_param #(.M(T_MAX), .W(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (proximo != estado),
    .conta (1'b1),
    .q     (tempo),
    .fim   (tempo_fim_unused)
  );

  assign jogada       = (botoes != '0) && (botoes_d == '0);
  assign correto      = (jogada_reg == (UM << mem_dado));
  assign ultimo_passo = ({1'b0, endereco} == rodada - RW'(1));
  assign esgotou      = (tempo == TW'(T_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:          if (iniciar) proximo = PREPARA;
      PREPARA:          proximo = MOSTRA;
      MOSTRA:           if (tempo == TW'(T_MOSTRA - 1)) proximo = INTERVALO;
      INTERVALO:        if (tempo == TW'(T_INTERVALO - 1)) proximo = PROX_MOSTRA;
      PROX_MOSTRA:      proximo = ultimo_passo ? INICIA_SEQ : MOSTRA;
      INICIA_SEQ:       proximo = ESPERA;
      ESPERA: begin
        if (jogada)       proximo = REGISTRA;
        else if (esgotou) proximo = PERDE_VIDA;
      end
      REGISTRA:         proximo = COMPARA;
      COMPARA: begin
        if (!correto)          proximo = PERDE_VIDA;
        else if (ultimo_passo) proximo = ULTIMA;
        else                   proximo = PROX_JOGADA;
      end
      PROX_JOGADA:      proximo = ESPERA;
      ULTIMA:           proximo = (rodada == comprimento) ? FINAL_ACERTOU : INTERVALO_RODADA;
      INTERVALO_RODADA: if (tempo == TW'(T_INTERVALO - 1)) proximo = PROX_RODADA;
      PROX_RODADA:      proximo = MOSTRA;
      PERDE_VIDA: begin
        if (vidas_restantes > VW'(1)) proximo = INTERVALO_RODADA;
        else if (causa_timeout)       proximo = FINAL_TIMEOUT;
        else                          proximo = FINAL_ERROU;
      end
      FINAL_ACERTOU, FINAL_ERROU, FINAL_TIMEOUT:
                        if (iniciar) proximo = PREPARA;
      default:          proximo = INICIAL;
    endcase
  end

  // Address, round, lives, play register and loss cause.
  always_ff @(posedge clock) begin
    if (reset) begin
      endereco        <= '0;
      rodada          <= '0;
      vidas_restantes <= '0;
      comprimento     <= '0;
      jogada_reg      <= '0;
      botoes_d        <= '0;
      causa_timeout   <= 1'b0;
      repete          <= 1'b0;
    end else begin
      botoes_d <= botoes;
      case (estado)
        PREPARA: begin
          comprimento     <= RW'(comprimento_jogo(MAX_SEQ, dificuldade));
          rodada          <= RW'(1);
          vidas_restantes <= VW'(VIDAS);
          endereco        <= '0;
          jogada_reg      <= '0;
          repete          <= 1'b0;
        end
        PROX_MOSTRA: if (!ultimo_passo) endereco <= endereco + AW'(1);
        INICIA_SEQ:  endereco <= '0;
        ESPERA:      if (!jogada && esgotou) causa_timeout <= 1'b1;
        REGISTRA:    jogada_reg <= botoes;
        COMPARA:     if (!correto) causa_timeout <= 1'b0;
        PROX_JOGADA: endereco <= endereco + AW'(1);
        PROX_RODADA: begin
          if (!repete) rodada <= rodada + RW'(1);
          repete   <= 1'b0;
          endereco <= '0;
        end
        PERDE_VIDA: begin
          endereco <= '0;
          if (vidas_restantes > VW'(1)) begin
            vidas_restantes <= vidas_restantes - VW'(1);
            repete          <= 1'b1;
          end else begin
            vidas_restantes <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags registered from the next state so they align with db_estado.
  always_ff @(posedge clock) begin
    if (reset) begin
      pronto      <= 1'b0;
      acertou     <= 1'b0;
      errou       <= 1'b0;
      fim_timeout <= 1'b0;
    end else begin
      pronto      <= (proximo == FINAL_ACERTOU) || (proximo == FINAL_ERROU) ||
                     (proximo == FINAL_TIMEOUT);
      acertou     <= (proximo == FINAL_ACERTOU);
      errou       <= (proximo == FINAL_ERROU);
      fim_timeout <= (proximo == FINAL_TIMEOUT);
    end
  end

  always_comb begin
    leds = '0;
    case (estado)
      MOSTRA:                    leds = UM << mem_dado;
      ESPERA, REGISTRA, COMPARA: leds = jogada_reg;
      default: ;
    endcase
  end

  assign mem_endereco = endereco;
  assign db_estado    = estado;

endmodule

// File: tb/tb_genius_controle_param.sv
// Directed bench for genius_controle_param: win, lives, timeout, held/multi press, reset, length.
module tb_genius_controle_param;
  import genius_pkg::*;

  logic       clock, reset, iniciar;
  logic [3:0] botoes;
  logic [1:0] dificuldade;
  logic [2:0] mem_endereco;
  logic [1:0] mem_dado;
  logic [3:0] leds;
  logic [3:0] rodada;
  logic [1:0] vidas_restantes;
  logic       pronto, acertou, errou, fim_timeout;
  logic [4:0] db_estado;

  logic [1:0] rom [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  assign mem_dado = rom[mem_endereco];

  int pass_cnt = 0;
  int total_cnt = 0;

  genius_controle_param #(
    .N_BOTOES(4), .MAX_SEQ(8), .T_MOSTRA(4), .T_INTERVALO(2),
    .T_TIMEOUT(20), .VIDAS(2)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .dificuldade(dificuldade), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
    .leds(leds), .rodada(rodada), .vidas_restantes(vidas_restantes),
    .pronto(pronto), .acertou(acertou), .errou(errou),
    .fim_timeout(fim_timeout), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_state(input logic [4:0] s, input string tag);
    int n = 0;
    while (db_estado !== s && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (db_estado !== s) check(tag, 32'(db_estado), 32'(s));
  endtask

  task automatic start(input logic [1:0] dif);
    dificuldade = dif;
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    check("start_prepara", 32'(db_estado), 32'(PREPARA));
    step(1);
    check("start_rodada", 32'(rodada), 32'd1);
    check("start_vidas", 32'(vidas_restantes), 32'd2);
  endtask

  // Walks a round-r show cycle by cycle, checking LEDs and phase lengths.
  task automatic check_show(input int r);
    logic [3:0] m;
    wait_state(MOSTRA, "show_start");
    for (int i = 0; i < r; i++) begin
      m = 4'b0001 << rom[i];
      for (int c = 0; c < 4; c++) begin
        check("show_led", 32'(leds), 32'(m));
        step(1);
      end
      check("show_interval", 32'(db_estado), 32'(INTERVALO));
      check("show_interval_dark", 32'(leds), 32'd0);
      step(3);
    end
    check("show_end", 32'(db_estado), 32'(INICIA_SEQ));
    step(1);
    check("show_espera", 32'(db_estado), 32'(ESPERA));
  endtask

  task automatic press(input logic [3:0] mask);
    wait_state(ESPERA, "press_wait");
    botoes = mask;
    step(2);
    botoes = 4'b0000;
  endtask

  task automatic count_espera(output int n);
    wait_state(ESPERA, "espera_wait");
    n = 0;
    while (db_estado === ESPERA && n < 100) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [3:0] m;
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] m;
    reset = 1'b1; iniciar = 1'b0; botoes = 4'b0; dificuldade = 2'b00;
    step(2);
    check("rst_state", 32'(db_estado), 32'(INICIAL));
    check("rst_outs", {16'd0, leds, rodada, mem_endereco, vidas_restantes,
                       pronto, acertou, errou, fim_timeout}, 32'd0);
    reset = 1'b0;
    step(2);
    check("idle_hold", 32'(db_estado), 32'(INICIAL));

    // Full win with L=2
    start(2'b00);
    check_show(1);
    press(4'b0001);
    check_show(2);
    press(4'b0001);
    press(4'b0010);
    wait_state(FINAL_ACERTOU, "win_wait");
    check("win_acertou", 32'(acertou), 32'd1);
    check("win_pronto", 32'(pronto), 32'd1);
    check("win_errou", 32'(errou), 32'd0);
    check("win_rodada", 32'(rodada), 32'd2);

    // Wrong play with a spare life, then game over on a second mistake
    start(2'b00);
    press(4'b0001);
    press(4'b0001);
    press(4'b0100);
    wait_state(INTERVALO_RODADA, "wrong_wait");
    check("wrong_vidas", 32'(vidas_restantes), 32'd1);
    check("wrong_rodada", 32'(rodada), 32'd2);
    check_show(2);
    press(4'b0001);
    press(4'b0100);
    wait_state(FINAL_ERROU, "lose_wait");
    check("lose_errou", 32'(errou), 32'd1);
    check("lose_vidas", 32'(vidas_restantes), 32'd0);
    check("lose_pronto", 32'(pronto), 32'd1);
    check("lose_acertou", 32'(acertou), 32'd0);

    // Timeout twice: first costs a life, second ends the game
    start(2'b00);
    count_espera(n);
    check("to1_len", 32'(n), 32'd20);
    check("to1_perde", 32'(db_estado), 32'(PERDE_VIDA));
    step(1);
    check("to1_replay", 32'(db_estado), 32'(INTERVALO_RODADA));
    check("to1_vidas", 32'(vidas_restantes), 32'd1);
    count_espera(n);
    check("to2_len", 32'(n), 32'd20);
    step(1);
    check("to2_final", 32'(db_estado), 32'(FINAL_TIMEOUT));
    check("to2_fim_timeout", 32'(fim_timeout), 32'd1);
    check("to2_errou", 32'(errou), 32'd0);
    check("to2_vidas", 32'(vidas_restantes), 32'd0);

    // Multi-button play is wrong; held button is not a play
    start(2'b01);
    press(4'b0011);
    wait_state(INTERVALO_RODADA, "multi_wait");
    check("multi_vidas", 32'(vidas_restantes), 32'd1);
    wait_state(INICIA_SEQ, "held_wait");
    botoes = 4'b0001;
    step(5);
    check("held_no_play", 32'(db_estado), 32'(ESPERA));
    botoes = 4'b0000;
    step(2);
    check("released_no_play", 32'(db_estado), 32'(ESPERA));
    press(4'b0001);
    wait_state(MOSTRA, "r2_wait");
    check("r2_rodada", 32'(rodada), 32'd2);
    check("r2_vidas", 32'(vidas_restantes), 32'd1);
    press(4'b0001);
    press(4'b0010);
    wait_state(MOSTRA, "r3_wait");
    check("r3_rodada", 32'(rodada), 32'd3);
    step(2);

    // Reset mid-show
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_state", 32'(db_estado), 32'(INICIAL));
    check("midrst_outs", {16'd0, leds, rodada, mem_endereco, vidas_restantes,
                          pronto, acertou, errou, fim_timeout}, 32'd0);

    // L=8 with dificuldade changed mid-game
    start(2'b11);
    for (int r = 1; r <= 8; r++) begin
      for (int i = 0; i < r; i++) begin
        m = 4'b0001 << rom[i];
        press(m);
      end
      if (r == 1) dificuldade = 2'b00;
      if (r == 3) dificuldade = 2'b01;
      n = 0;
      while (db_estado !== INTERVALO_RODADA && db_estado !== FINAL_ACERTOU && n < 50) begin
        step(1);
        n++;
      end
      check("long_state", 32'(db_estado), (r == 8) ? 32'(FINAL_ACERTOU) : 32'(INTERVALO_RODADA));
      check("long_rodada", 32'(rodada), 32'(r));
    end
    check("long_acertou", 32'(acertou), 32'd1);

    // Start honoured from a final state
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    check("restart_final", 32'(db_estado), 32'(PREPARA));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
